win_line_scanner: RTL and testbench

WIN_LINE_SCANNER -- requirements
Module: win_line_scanner

---
 rtl/win_line_scanner_if.sv | 29 ++
 rtl/win_line_scanner.sv | 202 ++++++++++++++++++++
 tb/tb_win_line_scanner.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/win_line_scanner_if.sv
// Check-request and board-read signals of the win-line scanner.
// master: requester plus board memory; slave: the scanner itself.
interface win_line_scanner_if #(
    parameter int RW = 3,
    parameter int CW = 3
) ();
    logic          start;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          rd_en;
    logic [RW-1:0] rd_row;
    logic [CW-1:0] rd_col;
    logic [1:0]    rd_data;
    logic          busy;
    logic          done;
    logic [1:0]    winner;
    logic [1:0]    win_axis;
    logic          bad_coord;

    modport master (
        output start, row, col, rd_data,
        input  rd_en, rd_row, rd_col, busy, done, winner, win_axis, bad_coord
    );

    modport slave (
        input  start, row, col, rd_data,
        output rd_en, rd_row, rd_col, busy, done, winner, win_axis, bad_coord
    );
endinterface

// File: rtl/win_line_scanner.sv
// Scans the four lines through an origin cell for a run of WIN_LEN equal pieces.
// Each axis is walked as a + ray then a - ray; the board is a 1-cycle-latency RAM.
module win_line_scanner #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4,
    parameter int RW      = 3,
    parameter int CW      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    win_line_scanner_if.slave  bus
);
    localparam int KW = $clog2(WIN_LEN);
    localparam int NW = $clog2(WIN_LEN + 1);

    typedef enum logic [2:0] {
        StIdle, StOrigin, StOriginChk, StProbe, StEval, StDone
    } state_e;

    state_e        state_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [1:0]    ref_q;
    logic [NW-1:0] run_q;
    logic [KW-1:0] k_q;
    logic [1:0]    axis_q;
    logic          neg_q;
    logic          rd_en_q;
    logic [RW-1:0] rd_row_q;
    logic [CW-1:0] rd_col_q;
    logic          busy_q;
    logic          done_q;
    logic [1:0]    winner_q;
    logic [1:0]    win_axis_q;
    logic          bad_q;

    // Returns {in_bounds, row, col} of origin + k*step. Arithmetic is done at int width so a
    // cell off either edge can never alias back onto the board.
    function automatic logic [RW+CW:0] probe_cell(input logic [RW-1:0] r0,
                                                  input logic [CW-1:0] c0,
                                                  input logic [1:0]    ax,
                                                  input logic          neg,
                                                  input logic [KW-1:0] k);
        int   dr, dc, rr, cc;
        logic inb;
        dr = (ax == 2'd1) ? 0 : 1;
        dc = (ax == 2'd0) ? 0 : ((ax == 2'd3) ? -1 : 1);
        if (neg) begin
            dr = -dr;
            dc = -dc;
        end
        rr  = int'(r0) + dr * int'(k);
        cc  = int'(c0) + dc * int'(k);
        inb = (rr >= 0) && (rr < ROWS) && (cc >= 0) && (cc < COLS);
        return {inb, rr[RW-1:0], cc[CW-1:0]};
    endfunction

    logic [RW+CW:0] cell_first, cell_cont, cell_ray;
    logic [1:0]     nr_axis;
    logic           nr_neg;
    logic [NW-1:0]  run_inc;
    logic           ray_end;

    // Candidate probe addresses for every way of entering PROBE, and the ray-end condition.
    always_comb begin
        nr_axis    = neg_q ? axis_q + 2'd1 : axis_q;
        nr_neg     = ~neg_q;
        run_inc    = run_q + NW'(1);
        cell_first = probe_cell(row_q, col_q, 2'd0, 1'b0, KW'(1));
        cell_cont  = probe_cell(row_q, col_q, axis_q, neg_q, k_q + KW'(1));
        cell_ray   = probe_cell(row_q, col_q, nr_axis, nr_neg, KW'(1));
        // In PROBE, rd_en_q low means the precomputed cell was off the board.
        ray_end    = ((state_q == StProbe) && !rd_en_q) ||
                     ((state_q == StEval) && (bus.rd_data != ref_q));
    end

    // Scanner FSM; all outputs are registered and the read address is set on entry to a state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            row_q      <= '0;
            col_q      <= '0;
            ref_q      <= 2'b00;
            run_q      <= '0;
            k_q        <= '0;
            axis_q     <= 2'd0;
            neg_q      <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            winner_q   <= 2'b00;
            win_axis_q <= 2'd0;
            bad_q      <= 1'b0;
        end else if (ray_end) begin
            rd_en_q <= 1'b0;
            if (neg_q && (axis_q == 2'd3)) begin
                state_q <= StDone;
                done_q  <= 1'b1;
            end else begin
                axis_q  <= nr_axis;
                neg_q   <= nr_neg;
                k_q     <= KW'(1);
                // The - ray extends the + ray's run; a new axis starts from the origin alone.
                if (neg_q) run_q <= NW'(1);
                rd_en_q <= cell_ray[RW+CW];
                if (cell_ray[RW+CW]) begin
                    rd_row_q <= cell_ray[RW+CW-1:CW];
                    rd_col_q <= cell_ray[CW-1:0];
                end
                state_q <= StProbe;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        row_q      <= bus.row;
                        col_q      <= bus.col;
                        winner_q   <= 2'b00;
                        win_axis_q <= 2'd0;
                        bad_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StOrigin;
                        // Origin read strobe is raised here so it is live during ORIGIN.
                        if ((int'(bus.row) < ROWS) && (int'(bus.col) < COLS)) begin
                            rd_en_q  <= 1'b1;
                            rd_row_q <= bus.row;
                            rd_col_q <= bus.col;
                        end
                    end
                end
                StOrigin: begin
                    rd_en_q <= 1'b0;
                    if ((int'(row_q) >= ROWS) || (int'(col_q) >= COLS)) begin
                        bad_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        state_q <= StOriginChk;
                    end
                end
                StOriginChk: begin
                    ref_q <= bus.rd_data;
                    if (bus.rd_data == 2'b00) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        run_q   <= NW'(1);
                        axis_q  <= 2'd0;
                        neg_q   <= 1'b0;
                        k_q     <= KW'(1);
                        rd_en_q <= cell_first[RW+CW];
                        if (cell_first[RW+CW]) begin
                            rd_row_q <= cell_first[RW+CW-1:CW];
                            rd_col_q <= cell_first[CW-1:0];
                        end
                        state_q <= StProbe;
                    end
                end
                StProbe: begin
                    rd_en_q <= 1'b0;
                    state_q <= StEval;
                end
                StEval: begin
                    // Only a matching cell reaches here; a mismatch is a ray end.
                    run_q <= run_inc;
                    if (run_inc == NW'(WIN_LEN)) begin
                        winner_q   <= ref_q;
                        win_axis_q <= axis_q;
                        done_q     <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        k_q     <= k_q + KW'(1);
                        rd_en_q <= cell_cont[RW+CW];
                        if (cell_cont[RW+CW]) begin
                            rd_row_q <= cell_cont[RW+CW-1:CW];
                            rd_col_q <= cell_cont[CW-1:0];
                        end
                        state_q <= StProbe;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_row    = rd_row_q;
    assign bus.rd_col    = rd_col_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.winner    = winner_q;
    assign bus.win_axis  = win_axis_q;
    assign bus.bad_coord = bad_q;
endmodule

// File: tb/tb_win_line_scanner.sv
// Directed bench: default 6x7/4 scanner plus an 8x8/5 instance for the parameter and reset sweep.
module tb_win_line_scanner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a, rst_n_b;
    logic go, sel;
    logic [2:0] orow, ocol;

    win_line_scanner_if #(.RW(3), .CW(3)) bus_a ();
    win_line_scanner_if #(.RW(3), .CW(3)) bus_b ();

    win_line_scanner #(.ROWS(6), .COLS(7), .WIN_LEN(4), .RW(3), .CW(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (bus_a)
    );

    win_line_scanner #(.ROWS(8), .COLS(8), .WIN_LEN(5), .RW(3), .CW(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (bus_b)
    );

    assign bus_a.start = go & ~sel;
    assign bus_a.row   = orow;
    assign bus_a.col   = ocol;
    assign bus_b.start = go & sel;
    assign bus_b.row   = orow;
    assign bus_b.col   = ocol;

    // Board RAM model, one-cycle read latency, shared by both instances.
    logic [1:0] board [8][8];
    always @(posedge clk) begin
        if (bus_a.rd_en) bus_a.rd_data <= board[bus_a.rd_row][bus_a.rd_col];
        if (bus_b.rd_en) bus_b.rd_data <= board[bus_b.rd_row][bus_b.rd_col];
    end

    logic       cur_done, cur_busy, cur_rd_en, cur_bad;
    logic [2:0] cur_rd_col;
    logic [1:0] cur_winner, cur_axis;
    assign cur_done   = sel ? bus_b.done      : bus_a.done;
    assign cur_busy   = sel ? bus_b.busy      : bus_a.busy;
    assign cur_rd_en  = sel ? bus_b.rd_en     : bus_a.rd_en;
    assign cur_bad    = sel ? bus_b.bad_coord : bus_a.bad_coord;
    assign cur_rd_col = sel ? bus_b.rd_col    : bus_a.rd_col;
    assign cur_winner = sel ? bus_b.winner    : bus_a.winner;
    assign cur_axis   = sel ? bus_b.win_axis  : bus_a.win_axis;

    logic [13:0] outs_a, outs_b;
    assign outs_a = {bus_a.busy, bus_a.done, bus_a.rd_en, bus_a.rd_row, bus_a.rd_col,
                     bus_a.winner, bus_a.win_axis, bus_a.bad_coord};
    assign outs_b = {bus_b.busy, bus_b.done, bus_b.rd_en, bus_b.rd_row, bus_b.rd_col,
                     bus_b.winner, bus_b.win_axis, bus_b.bad_coord};

    // Free-running read counters; each check works on differences.
    int rd_total = 0;
    int col0_total = 0;
    always @(posedge clk) begin
        if (cur_rd_en) begin
            rd_total = rd_total + 1;
            if (cur_rd_col == 3'd0) col0_total = col0_total + 1;
        end
    end

    typedef struct {
        bit         b;     // 1 = 8x8/WIN_LEN 5 instance
        int         r0, c0;
        logic [1:0] ov;    // origin cell value
        logic [1:0] cv;    // value of the listed cells
        int         n;
        logic [23:0] cl;   // up to four {row,col} octal pairs, entry 0 in the low bits
        logic [1:0] ew, ea;
        logic       eb;
        int         elat, erd, ec0;
    } vec_t;

    vec_t vecs[9];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(bit b, int r0, int c0, logic [1:0] ov, logic [1:0] cv, int n,
                                logic [23:0] cl, logic [1:0] ew, logic [1:0] ea, logic eb,
                                int elat, int erd, int ec0);
        vec_t v;
        v.b = b; v.r0 = r0; v.c0 = c0; v.ov = ov; v.cv = cv; v.n = n; v.cl = cl;
        v.ew = ew; v.ea = ea; v.eb = eb; v.elat = elat; v.erd = erd; v.ec0 = ec0;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_board(input vec_t v);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) board[r][c] = 2'b00;
        if (v.r0 < 8 && v.c0 < 8) board[v.r0][v.c0] = v.ov;
        for (int k = 0; k < v.n; k++) board[v.cl[k*6+3 +: 3]][v.cl[k*6 +: 3]] = v.cv;
    endtask

    // Entered at cycle 1 (the cycle after acceptance); waits for done and checks the result.
    task automatic finish_vec(input vec_t v, input string t, input int rs, input int cs,
                              input bit poke);
        int cyc = 1;
        while (!cur_done && cyc < 200) begin
            if (poke && cyc == 6) begin
                orow = 3'd0;
                ocol = 3'd0;
                go   = 1'b1;
            end
            if (poke && cyc == 8) go = 1'b0;
            @(negedge clk);
            cyc++;
        end
        go = 1'b0;
        chk({t, "_latency"}, cyc, v.elat);
        chk({t, "_winner"}, int'(cur_winner), int'(v.ew));
        chk({t, "_axis"}, int'(cur_axis), int'(v.ea));
        chk({t, "_bad"}, int'(cur_bad), int'(v.eb));
        chk({t, "_reads"}, rd_total - rs, v.erd);
        chk({t, "_col0_reads"}, col0_total - cs, v.ec0);
        // Start during the DONE cycle must be ignored.
        orow = 3'd3;
        ocol = 3'd3;
        go   = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk({t, "_done_pulse_ends"}, int'({cur_done, cur_busy}), 0);
        repeat (2) @(negedge clk);
        chk({t, "_hold"}, int'({cur_winner, cur_axis, cur_bad}), int'({v.ew, v.ea, v.eb}));
    endtask

    task automatic run_vec(input vec_t v, input string t, input bit poke);
        int rs, cs;
        load_board(v);
        sel = v.b;
        @(negedge clk);
        rs   = rd_total;
        cs   = col0_total;
        orow = 3'(v.r0);
        ocol = 3'(v.c0);
        go   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        finish_vec(v, t, rs, cs, poke);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rs, cs, dcount;
        go = 1'b0; sel = 1'b0; orow = 3'd0; ocol = 3'd0;
        rst_n_a = 1'b0; rst_n_b = 1'b0;

        //             b  r0 c0 ov     cv     n  cells                              ew     ea eb lat rd c0
        vecs[0] = mk(0, 2, 2, 2'b10, 2'b10, 3, {6'o00, 6'o00, 6'o11, 6'o33}, 2'b10, 2, 0, 19, 9, 1);
        vecs[1] = mk(0, 2, 3, 2'b00, 2'b00, 0, 24'd0,                        2'b00, 0, 0, 3,  1, 0);
        vecs[2] = mk(0, 3, 4, 2'b01, 2'b01, 3, {6'o00, 6'o04, 6'o14, 6'o24}, 2'b01, 0, 0, 11, 5, 0);
        vecs[3] = mk(0, 1, 3, 2'b10, 2'b10, 3, {6'o00, 6'o11, 6'o12, 6'o14}, 2'b10, 1, 0, 15, 7, 0);
        vecs[4] = mk(0, 0, 6, 2'b01, 2'b01, 3, {6'o00, 6'o10, 6'o21, 6'o32}, 2'b00, 0, 0, 14, 4, 0);
        vecs[5] = mk(0, 5, 0, 2'b11, 2'b11, 3, {6'o00, 6'o41, 6'o32, 6'o23}, 2'b11, 3, 0, 18, 6, 2);
        vecs[6] = mk(0, 6, 2, 2'b01, 2'b01, 0, 24'd0,                        2'b00, 0, 1, 2,  0, 0);
        vecs[7] = mk(0, 2, 3, 2'b01, 2'b10, 1, {18'd0, 6'o33},               2'b00, 0, 0, 19, 9, 0);
        vecs[8] = mk(1, 2, 2, 2'b01, 2'b01, 4, {6'o40, 6'o31, 6'o13, 6'o04}, 2'b01, 3, 0, 24, 11, 1);

        repeat (2) @(negedge clk);
        chk("reset_outs_a", int'(outs_a), 0);
        chk("reset_outs_b", int'(outs_b), 0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i), 1'b0);

        // Start pulsed while busy must not disturb the running check.
        run_vec(vecs[0], "busy_start", 1'b1);

        // Abort the 8x8 check mid-PROBE, then restart on the first edge after reset release.
        load_board(vecs[8]);
        sel = 1'b1;
        @(negedge clk);
        orow = 3'd2;
        ocol = 3'd2;
        go   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_in_probe_rd_en", int'(bus_b.rd_en), 1);
        rst_n_b = 1'b0;
        #1;
        chk("abort_reset_outs", int'(outs_b), 0);
        dcount = 0;
        repeat (3) @(negedge clk);
        rst_n_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_b.done || bus_b.busy) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        rst_n_b = 1'b0;
        @(negedge clk);
        rs   = rd_total;
        cs   = col0_total;
        go   = 1'b1;
        rst_n_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        chk("restart_busy", int'(bus_b.busy), 1);
        finish_vec(vecs[8], "restart", rs, cs, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
